// File: rtl/led_pwm_pio.sv
// Avalon-MM LED peripheral: WIDTH channels, each static, blinking or PWM-driven.
// One shared prescaler/PWM/blink timebase; per-channel duty shadowing and mux live in led_pwm_lane.

module led_pwm_lane #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                boundary,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                pwm_en,
  input  logic                blink_en,
  input  logic                data,
  input  logic                phase,
  output logic                lane_out
);
  logic [PWM_BITS-1:0] act_duty_q, act_duty_d;

  // compare duty only follows the bus-visible value at a period boundary
  always_comb begin
    act_duty_d = act_duty_q;
    if (boundary) act_duty_d = duty;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) act_duty_q <= '0;
    else                act_duty_q <= act_duty_d;
  end

  always_comb begin
    lane_out = data;
    if (pwm_en)        lane_out = (pwm_cnt < act_duty_q);
    else if (blink_en) lane_out = data & phase;
  end
endmodule

module led_pwm_pio #(
  parameter int WIDTH    = 8,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 500
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [4:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic [WIDTH-1:0] led_wire_export
);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [WIDTH-1:0]                data_q, data_d;
  logic [WIDTH-1:0]                pwm_en_q, pwm_en_d;
  logic [WIDTH-1:0]                blink_en_q, blink_en_d;
  logic [15:0]                     blink_per_q, blink_per_d;
  logic [WIDTH-1:0][PWM_BITS-1:0]  duty_q, duty_d;
  logic [PRE_W-1:0]                pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0]             pwm_cnt_q, pwm_cnt_d;
  logic [15:0]                     bl_cnt_q, bl_cnt_d;
  logic                            phase_q, phase_d;
  logic [WIDTH-1:0]                led_q, led_d;
  logic [31:0]                     rdata_q, rdata_d;
  logic [31:0]                     rd_mux;
  logic                            tick, boundary, per_wr;
  logic                            unused_wd;

  assign unused_wd = ^avs_writedata;

  always_comb begin
    data_d      = data_q;
    pwm_en_d    = pwm_en_q;
    blink_en_d  = blink_en_q;
    blink_per_d = blink_per_q;
    duty_d      = duty_q;
    per_wr      = avs_write && (avs_address == 5'd3);
    if (avs_write) begin
      case (avs_address)
        5'd0:    data_d      = avs_writedata[WIDTH-1:0];
        5'd1:    pwm_en_d    = avs_writedata[WIDTH-1:0];
        5'd2:    blink_en_d  = avs_writedata[WIDTH-1:0];
        5'd3:    blink_per_d = avs_writedata[15:0];
        default: ;
      endcase
      for (int ch = 0; ch < WIDTH; ch++)
        if (avs_address == 5'(16 + ch)) duty_d[ch] = avs_writedata[PWM_BITS-1:0];
    end
  end

  always_comb begin
    tick      = (pre_cnt_q == PRE_MAX);
    boundary  = tick && (&pwm_cnt_q);
    pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    pwm_cnt_d = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    bl_cnt_d  = bl_cnt_q;
    phase_d   = phase_q;
    // a new half-period restarts the blink from the high phase
    if (per_wr) begin
      bl_cnt_d = '0;
      phase_d  = 1'b1;
    end else if (tick) begin
      if (blink_per_q == 16'd0) begin
        bl_cnt_d = '0;
        phase_d  = 1'b1;
      end else if (bl_cnt_q == blink_per_q - 16'd1) begin
        bl_cnt_d = '0;
        phase_d  = ~phase_q;
      end else begin
        bl_cnt_d = bl_cnt_q + 16'd1;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_lane
      led_pwm_lane #(.PWM_BITS(PWM_BITS)) u_lane (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .boundary      (boundary),
        .duty          (duty_q[g]),
        .pwm_cnt       (pwm_cnt_q),
        .pwm_en        (pwm_en_q[g]),
        .blink_en      (blink_en_q[g]),
        .data          (data_q[g]),
        .phase         (phase_q),
        .lane_out      (led_d[g])
      );
    end
  endgenerate

  // reads see pre-write state, so a same-cycle read+write returns the old value
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      5'd0:    rd_mux[WIDTH-1:0] = data_q;
      5'd1:    rd_mux[WIDTH-1:0] = pwm_en_q;
      5'd2:    rd_mux[WIDTH-1:0] = blink_en_q;
      5'd3:    rd_mux[15:0]      = blink_per_q;
      5'd4:    rd_mux[WIDTH-1:0] = led_q;
      default: ;
    endcase
    for (int ch = 0; ch < WIDTH; ch++)
      if (avs_address == 5'(16 + ch)) rd_mux[PWM_BITS-1:0] = duty_q[ch];
    rdata_d = avs_read ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      data_q      <= '0;
      pwm_en_q    <= '0;
      blink_en_q  <= '0;
      blink_per_q <= '0;
      duty_q      <= '0;
      pre_cnt_q   <= '0;
      pwm_cnt_q   <= '0;
      bl_cnt_q    <= '0;
      phase_q     <= 1'b1;
      led_q       <= '0;
      rdata_q     <= '0;
    end else begin
      data_q      <= data_d;
      pwm_en_q    <= pwm_en_d;
      blink_en_q  <= blink_en_d;
      blink_per_q <= blink_per_d;
      duty_q      <= duty_d;
      pre_cnt_q   <= pre_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      bl_cnt_q    <= bl_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
      rdata_q     <= rdata_d;
    end
  end

  assign avs_readdata    = rdata_q;
  assign led_wire_export = led_q;
endmodule

// File: tb/tb_led_pwm_pio.sv
// Scoreboard bench for led_pwm_pio (WIDTH=8, PWM_BITS=4, PRESCALE=2): one PWM period = 32 clocks.
// Stimulus queues expectations; a single negedge monitor pops them when reads, checks or windows complete.
module tb_led_pwm_pio;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic [7:0]  led;

  led_pwm_pio #(.WIDTH(8), .PWM_BITS(4), .PRESCALE(2)) dut (
    .clk_clk         (clk),
    .reset_reset_n   (rst_n),
    .avs_address     (avs_address),
    .avs_read        (avs_read),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .led_wire_export (led)
  );

  always #5 clk = ~clk;

  typedef struct {string name; bit is_rd; logic [31:0] mask; logic [31:0] exp;} chk_t;
  typedef struct {string name; logic [31:0] exp;} rd_t;
  typedef struct {string name; int exp;} win_t;

  chk_t chk_q[$];
  rd_t  rd_q[$];
  win_t win_q[$];

  int   n_vec = 0, n_err = 0;
  int   ecnt = 0;
  logic rd_pend = 1'b0, chk_go = 1'b0, win_go = 1'b0, done = 1'b0;

  // non-reset edges since reset release: tick lands on even counts, period start on 32j+1
  always @(posedge clk) ecnt <= rst_n ? ecnt + 1 : 0;
  always @(posedge clk) rd_pend <= avs_read;

  chk_t c;
  rd_t  r;
  win_t w;
  logic [31:0] val;
  bit   win_act = 1'b0;
  int   win_n = 0, win_cnt = 0;

  always @(negedge clk) begin
    if (rd_pend) begin
      n_vec++;
      if (rd_q.size() == 0) begin
        n_err++; $display("FAIL rd_underflow: unexpected read response %h", avs_readdata);
      end else begin
        r = rd_q.pop_front();
        if (avs_readdata !== r.exp) begin
          n_err++; $display("FAIL %s: readdata=%h expected=%h", r.name, avs_readdata, r.exp);
        end
      end
    end
    if (chk_go) begin
      n_vec++;
      c = chk_q.pop_front();
      val = c.is_rd ? avs_readdata : {24'b0, led};
      if ((val & c.mask) !== c.exp) begin
        n_err++; $display("FAIL %s: got=%h expected=%h (mask %h)", c.name, val & c.mask, c.exp, c.mask);
      end
    end
    if (!win_act && win_go) begin
      win_act = 1'b1; win_n = 0; win_cnt = 0;
    end
    if (win_act) begin
      win_cnt += int'(led[0]);
      win_n++;
      if (win_n == 32) begin
        win_act = 1'b0;
        n_vec++;
        w = win_q.pop_front();
        if (win_cnt != w.exp) begin
          n_err++; $display("FAIL %s: led[0] high %0d of 32 cycles, expected %0d", w.name, win_cnt, w.exp);
        end
      end
    end
    if (done) begin
      if (rd_q.size() != 0 || chk_q.size() != 0 || win_q.size() != 0 || win_act) begin
        n_vec++; n_err++;
        $display("FAIL drain: %0d reads %0d checks %0d windows outstanding", rd_q.size(), chk_q.size(), win_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    avs_write = 1'b1; avs_address = a; avs_writedata = d;
    cyc();
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string n);
    avs_read = 1'b1; avs_address = a;
    rd_q.push_back('{n, e});
    cyc();
    avs_read = 1'b0;
  endtask

  task automatic chk(input bit is_rd, input logic [31:0] m, input logic [31:0] e, input string n);
    chk_q.push_back('{n, is_rd, m, e});
    chk_go = 1'b1;
    @(negedge clk); #1;
    chk_go = 1'b0;
  endtask

  task automatic win(input int e, input string n);
    win_q.push_back('{n, e});
    win_go = 1'b1;
    @(negedge clk); #1;
    win_go = 1'b0;
  endtask

  // skip at least one boundary, then stop on the first cycle of a period
  task automatic to_period_start();
    cyc(); cyc();
    for (int i = 0; i < 40 && (ecnt % 32) != 1; i++) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    // reset, with a DATA write that must be ignored
    avs_write = 1'b1; avs_address = 5'd0; avs_writedata = 32'hA5;
    repeat (3) cyc();
    chk(0, 32'hFF, 32'h00, "rst_led");
    chk(1, 32'hFFFF_FFFF, 32'h0, "rst_readdata");
    rst_n = 1'b1; avs_write = 1'b0;
    cyc(); cyc();
    chk(0, 32'hFF, 32'h00, "post_rst_led");
    rd(5'd0, 32'h0, "post_rst_data");

    // static output and register reads
    wr(5'd0, 32'hFFFF_FF3C);
    chk(0, 32'hFF, 32'h00, "static_n1");
    cyc();
    chk(0, 32'hFF, 32'h3C, "static_n2");
    rd(5'd4, 32'h3C, "status");
    rd(5'd2, 32'h0, "blink_en_rd");
    rd(5'd20, 32'h0, "duty4_rd");
    rd(5'd24, 32'h0, "unmapped_rd");

    // simultaneous read+write returns the pre-write value
    avs_read = 1'b1; avs_write = 1'b1; avs_address = 5'd0; avs_writedata = 32'h11;
    rd_q.push_back('{"rw_old", 32'h3C});
    cyc();
    avs_read = 1'b0; avs_write = 1'b0;
    rd(5'd0, 32'h11, "rw_new");

    // PWM duty sweep (4 ticks -> 8 clocks, 0 -> 0, 15 -> 30)
    wr(5'd1, 32'h01);
    wr(5'd16, 32'hF4);
    to_period_start(); win(8, "pwm_d4");
    wr(5'd16, 32'h0);
    to_period_start(); win(0, "pwm_d0");
    wr(5'd16, 32'hF);
    to_period_start(); win(30, "pwm_d15");
    wr(5'd16, 32'h4);

    // shadowing: mid-period change only shows from the next period
    to_period_start(); win(8, "shadow_cur");
    repeat (5) cyc();
    wr(5'd16, 32'hC);
    rd(5'd16, 32'hC, "duty_readback");
    to_period_start(); win(24, "shadow_next");

    // blink: half-period 3 ticks = 6 clocks, starting high
    wr(5'd0, 32'h80);
    wr(5'd2, 32'h80);
    if (ecnt % 2 == 0) cyc();
    wr(5'd3, 32'hABCD_0003);
    for (int k = 1; k <= 18; k++) begin
      cyc();
      chk(0, 32'h80, (((k - 1) / 6) % 2 == 0) ? 32'h80 : 32'h00, $sformatf("blink_k%0d", k));
    end
    wr(5'd3, 32'h0);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (k == 2 || k == 5 || k == 9) chk(0, 32'h80, 32'h80, $sformatf("blink_solid_k%0d", k));
    end

    // reset in the middle of a PWM high phase
    to_period_start();
    cyc(); cyc();
    chk(0, 32'hFF, 32'h81, "pre_rst_led");
    rst_n = 1'b0;
    cyc();
    chk(0, 32'hFF, 32'h00, "mid_rst_led");
    chk(1, 32'hFFFF_FFFF, 32'h0, "mid_rst_readdata");
    rst_n = 1'b1;
    rd(5'd16, 32'h0, "mid_rst_duty");
    rd(5'd1, 32'h0, "mid_rst_pwm_en");
    rd(5'd3, 32'h0, "mid_rst_blink_per");
    repeat (3) cyc();
    done = 1'b1;
  end
endmodule
